seq_divider: RTL

SEQ_DIVIDER -- requirements
Module: seq_divider

---
 rtl/div_pkg.sv | 19 +
 rtl/add_subtract.sv | 21 ++
 rtl/seq_divider.sv | 139 +++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider: FSM state type, default
// operand width and iteration-counter sizing.
package div_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } div_state_t;

   localparam int unsigned DIV_WIDTH_DEF = 8;
   localparam int unsigned DIV_CNT_W     = $clog2(DIV_WIDTH_DEF) + 1;

   // Counter width for an arbitrary operand width; wide enough to hold WIDTH.
   function automatic int unsigned div_cnt_width(input int unsigned width);
      return $clog2(width) + 1;
   endfunction

endpackage

// File: rtl/add_subtract.sv
// Shared adder/subtractor: add_sub=1 computes a - b as a + ~b + 1, and the
// carry out then means "no borrow" (a >= b).
module add_subtract #(
   parameter int unsigned WIDTH = 9
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             add_sub,
   output logic [WIDTH-1:0] result,
   output logic             carry
);

   logic [WIDTH-1:0] b_eff;

   // Two's-complement add/subtract with carry out.
   always_comb begin
      b_eff           = add_sub ? ~b : b;
      {carry, result} = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, add_sub};
   end

endmodule

// File: rtl/seq_divider.sv
// Unsigned restoring divider, one quotient bit per RUN cycle, MSB first.
// Optional macro DIV_ZERO_FAST_EN: a zero divisor skips RUN and goes
// straight to DONE with the divide-by-zero result.
module seq_divider
   import div_pkg::*;
#(
   parameter int unsigned WIDTH = DIV_WIDTH_DEF
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic [WIDTH-1:0] dividend_i,
   input  logic [WIDTH-1:0] divisor_i,
   output logic [WIDTH-1:0] quotient_o,
   output logic [WIDTH-1:0] remainder_o,
   output logic             busy_o,
   output logic             done_o,
   output logic             div_zero_o
);

   localparam int unsigned    CNT_W = div_cnt_width(WIDTH);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

   div_state_t       state;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] dvd;
   logic [WIDTH-1:0] dvs;
   logic [WIDTH-1:0] rem;
   logic [WIDTH-1:0] quo;

   logic [WIDTH:0]   shifted;
   logic [WIDTH:0]   diff;
   logic             no_borrow;
   logic [WIDTH-1:0] rem_next;
   logic [WIDTH-1:0] quo_next;
   logic             unused_bits;

   // Partial remainder shifted left with the next dividend bit brought in.
   always_comb begin
      shifted = {rem, dvd[WIDTH-1]};
   end

   generate
      if (WIDTH == 8) begin : g_addsub
         add_subtract #(
            .WIDTH (WIDTH + 1)
         ) u_addsub (
            .a       (shifted),
            .b       ({1'b0, dvs}),
            .add_sub (1'b1),
            .result  (diff),
            .carry   (no_borrow)
         );
      end else begin : g_inline
         logic [WIDTH+1:0] full;
         // Equivalent WIDTH+1-bit trial subtract; the extra top bit is the borrow.
         always_comb begin
            full      = {1'b0, shifted} - {2'b00, dvs};
            diff      = full[WIDTH:0];
            no_borrow = ~full[WIDTH+1];
         end
      end
   endgenerate

   // Keep the difference on no borrow, otherwise restore the shifted value.
   always_comb begin
      rem_next    = no_borrow ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
      quo_next    = {quo[WIDTH-2:0], no_borrow};
      unused_bits = diff[WIDTH] ^ shifted[WIDTH];
   end

   // Control FSM with datapath registers and registered outputs.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state       <= IDLE;
         cnt         <= '0;
         dvd         <= '0;
         dvs         <= '0;
         rem         <= '0;
         quo         <= '0;
         quotient_o  <= '0;
         remainder_o <= '0;
         busy_o      <= 1'b0;
         done_o      <= 1'b0;
         div_zero_o  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done_o <= 1'b0;
               if (start_i) begin
                  dvd    <= dividend_i;
                  dvs    <= divisor_i;
                  rem    <= '0;
                  quo    <= '0;
                  cnt    <= '0;
                  busy_o <= 1'b1;
`ifdef DIV_ZERO_FAST_EN
                  if (divisor_i == '0) begin
                     state       <= DONE;
                     done_o      <= 1'b1;
                     quotient_o  <= '1;
                     remainder_o <= dividend_i;
                     div_zero_o  <= 1'b1;
                  end else begin
                     state <= RUN;
                  end
`else
                  state <= RUN;
`endif
               end
            end
            RUN: begin
               dvd <= dvd << 1;
               rem <= rem_next;
               quo <= quo_next;
               cnt <= cnt + 1'b1;
               if (cnt == LAST) begin
                  state       <= DONE;
                  done_o      <= 1'b1;
                  quotient_o  <= quo_next;
                  remainder_o <= rem_next;
                  div_zero_o  <= (dvs == '0);
               end
            end
            DONE: begin
               state  <= IDLE;
               busy_o <= 1'b0;
               done_o <= 1'b0;
            end
            default: begin
               state  <= IDLE;
               busy_o <= 1'b0;
               done_o <= 1'b0;
            end
         endcase
      end
   end

endmodule
